// File: rtl/enigma_ctrl.sv
// ============================================================================
// Module   : enigma_ctrl
// Function : Enigma sequencer - rotor stepping plus nine-stage routing over a
//            shared stage bus with per-stage timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module enigma_ctrl #(
    parameter int TIMEOUT     = 8,
    parameter int NOTCH_L_RST = 16,
    parameter int NOTCH_M_RST = 4,
    parameter int NOTCH_R_RST = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic [14:0] cfg_pos,
    input  logic [14:0] cfg_notch,
    input  logic        valid,
    input  logic [7:0]  din,
    output logic        ready,
    output logic [7:0]  dout,
    output logic        done,
    output logic        err,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        stg_valid,
    output logic [3:0]  stg_sel,
    output logic [7:0]  stg_din,
    output logic        stg_dec,
    input  logic [7:0]  stg_dout,
    input  logic        stg_done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_STEP  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] c_K_LAST   = 4'd8;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [4:0] r_pos_l, r_pos_m, r_pos_r;
    logic [4:0] r_notch_l, r_notch_m, r_notch_r;
    logic [7:0] r_char;
    logic [3:0] r_k;
    logic [7:0] r_tmo;
    logic [7:0] r_dout;
    logic       r_err;
    logic       w_is_letter;
    logic       w_tmo_hit;

    function automatic logic [4:0] f_mod26(input logic [4:0] v);
        return (v > 5'd25) ? v - 5'd26 : v;
    endfunction

    function automatic logic [4:0] f_inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    assign w_is_letter = (din >= 8'd65) && (din <= 8'd90);
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (valid) w_state_nxt = w_is_letter ? c_STEP : c_DONE;
            c_STEP:  w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (stg_done) begin
                    w_state_nxt = (r_k == c_K_LAST) ? c_DONE : c_ISSUE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        ready     = (r_state == c_IDLE);
        stg_valid = (r_state == c_ISSUE);
        done      = (r_state == c_DONE);
    end

    // Stage bus mirrors the working registers, so it stays put throughout WAIT.
    assign stg_sel = r_k;
    assign stg_din = r_char;
    assign stg_dec = (r_k >= 4'd5);
    assign dout    = r_dout;
    assign err     = r_err;
    assign pos_l   = r_pos_l;
    assign pos_m   = r_pos_m;
    assign pos_r   = r_pos_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_l   <= 5'd0;
            r_pos_m   <= 5'd0;
            r_pos_r   <= 5'd0;
            r_notch_l <= 5'(NOTCH_L_RST);
            r_notch_m <= 5'(NOTCH_M_RST);
            r_notch_r <= 5'(NOTCH_R_RST);
            r_char    <= 8'd0;
            r_k       <= 4'd0;
            r_tmo     <= 8'd0;
            r_dout    <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            r_dout <= 8'd0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (set) begin
                        r_pos_l   <= f_mod26(cfg_pos[14:10]);
                        r_pos_m   <= f_mod26(cfg_pos[9:5]);
                        r_pos_r   <= f_mod26(cfg_pos[4:0]);
                        r_notch_l <= f_mod26(cfg_notch[14:10]);
                        r_notch_m <= f_mod26(cfg_notch[9:5]);
                        r_notch_r <= f_mod26(cfg_notch[4:0]);
                    end
                    if (valid) begin
                        r_char <= din;
                        if (!w_is_letter) r_dout <= din;
                    end
                end
                c_STEP: begin
                    // Middle rotor double-steps on its own notch; all tests use pre-step values.
                    r_pos_r <= f_inc26(r_pos_r);
                    if ((r_pos_r == r_notch_r) || (r_pos_m == r_notch_m)) r_pos_m <= f_inc26(r_pos_m);
                    if (r_pos_m == r_notch_m) r_pos_l <= f_inc26(r_pos_l);
                    r_k <= 4'd0;
                end
                c_ISSUE: r_tmo <= 8'd0;
                c_WAIT: begin
                    r_tmo <= r_tmo + 8'd1;
                    if (stg_done) begin
                        r_char <= stg_dout;
                        if (r_k == c_K_LAST) r_dout <= stg_dout;
                        else                 r_k <= r_k + 4'd1;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_enigma_ctrl.sv
// ============================================================================
// Module   : tb_enigma_ctrl
// Function : Self-checking bench for enigma_ctrl with stub stages and a
//            rotor reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_enigma_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set = 1'b0;
    logic [14:0] cfg_pos = '0;
    logic [14:0] cfg_notch = '0;
    logic        valid = 1'b0;
    logic [7:0]  din = '0;
    logic        ready, done, err, stg_valid, stg_dec;
    logic [7:0]  dout, stg_din;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic [3:0]  stg_sel;
    logic [7:0]  stg_dout = '0;
    logic        stg_done = 1'b0;

    int checks = 0;
    int errors = 0;

    // Stub stage behaviour and observation log
    int          stub_lat = 0;
    logic [3:0]  hang_sel = 4'hF;
    logic [12:0] req_q[$];   // {sel, dec, din}

    // Reference rotor model
    int pl, pm, pr, nl, nm, nr;

    enigma_ctrl #(.TIMEOUT(8), .NOTCH_L_RST(16), .NOTCH_M_RST(4), .NOTCH_R_RST(21)) dut (
        .clk(clk), .reset(reset), .set(set), .cfg_pos(cfg_pos), .cfg_notch(cfg_notch),
        .valid(valid), .din(din), .ready(ready), .dout(dout), .done(done), .err(err),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .stg_valid(stg_valid),
        .stg_sel(stg_sel), .stg_din(stg_din), .stg_dec(stg_dec),
        .stg_dout(stg_dout), .stg_done(stg_done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk); #1;
            stg_done = 1'b0;
            if (stg_valid === 1'b1) begin
                req_q.push_back({stg_sel, stg_dec, stg_din});
                if (stg_sel !== hang_sel) begin
                    logic [7:0] v;
                    v = stg_din + 8'd1;
                    repeat (1 + stub_lat) @(posedge clk);
                    #1;
                    stg_done = 1'b1;
                    stg_dout = v;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'd65) && (c <= 8'd90);
    endfunction

    task automatic model_reset();
        pl = 0; pm = 0; pr = 0; nl = 16; nm = 4; nr = 21;
    endtask

    task automatic model_load(input logic [14:0] p, input logic [14:0] n);
        pl = int'(p[14:10]) % 26; pm = int'(p[9:5]) % 26; pr = int'(p[4:0]) % 26;
        nl = int'(n[14:10]) % 26; nm = int'(n[9:5]) % 26; nr = int'(n[4:0]) % 26;
    endtask

    task automatic model_step();
        bit sm, sl;
        sm = (pr == nr) || (pm == nm);
        sl = (pm == nm);
        pr = (pr + 1) % 26;
        if (sm) pm = (pm + 1) % 26;
        if (sl) pl = (pl + 1) % 26;
    endtask

    function automatic logic [14:0] model_pos();
        return {5'(pl), 5'(pm), 5'(pr)};
    endfunction

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Send one character (optionally with set in the same cycle); returns result
    task automatic send(input logic [7:0] c, input bit do_set, input logic [14:0] p,
                        input logic [14:0] n, output logic [7:0] r_d, output logic r_e,
                        output int lat);
        chk("ready_before", {31'd0, ready}, 32'd1);
        req_q.delete();
        valid = 1'b1; din = c; set = do_set; cfg_pos = p; cfg_notch = n;
        @(posedge clk); #1;
        valid = 1'b0; set = 1'b0;
        wait_done(lat);
        r_d = dout; r_e = err;
        @(posedge clk); #1;
        chk("ready_after", {31'd0, ready}, 32'd1);
        chk("dout_idle", {24'd0, dout}, 32'd0);
    endtask

    initial begin
        logic [7:0]  rd, c;
        logic        re;
        int          lat;
        logic [14:0] p, n;
        bit          ds;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_stg", {18'd0, stg_valid, stg_sel, stg_din, stg_dec}, 32'd0);
        chk("rst_pos", {17'd0, pos_l, pos_m, pos_r}, 32'd0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Double-step sequence ADU -> ADV, AEW, BFX
        p = {5'd0, 5'd3, 5'd20};
        n = {5'd16, 5'd4, 5'd21};
        model_load(p, n);
        for (int i = 0; i < 3; i++) begin
            send("A", i == 0, p, n, rd, re, lat);
            model_step();
            chk("dstep_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});
            chk("dstep_dout", {24'd0, rd}, 32'h4A);
        end
        chk("dstep_final_BFX", {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'd1, 5'd5, 5'd23});
        chk("letter_latency", lat, 20);
        chk("stage_count", req_q.size(), 9);
        for (int k = 0; k < 9; k++) begin
            logic [12:0] e;
            e = {4'(k), (k >= 5), 8'h41 + 8'(k)};
            if (k < req_q.size()) chk("stage_req", {19'd0, req_q[k]}, {19'd0, e});
        end

        // Right rotor wrap 25 -> 0
        p = {5'd0, 5'd0, 5'd25};
        model_load(p, n);
        send("Q", 1'b1, p, n, rd, re, lat);
        model_step();
        chk("wrap_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});

        // Non-letter passes straight through
        send(8'h35, 1'b0, '0, '0, rd, re, lat);
        chk("nonletter_dout", {24'd0, rd}, 32'h35);
        chk("nonletter_latency", lat, 1);
        chk("nonletter_no_stg", req_q.size(), 0);
        chk("nonletter_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});

        // Randomized characters, configs and stage latencies
        for (int i = 0; i < 40; i++) begin
            ds = ($urandom_range(0, 3) == 0);
            p = 15'($urandom);
            n = 15'($urandom);
            if ($urandom_range(0, 4) == 0) c = 8'($urandom);
            else                           c = 8'(65 + $urandom_range(0, 25));
            stub_lat = $urandom_range(0, 3);
            send(c, ds, p, n, rd, re, lat);
            if (ds) model_load(p, n);
            if (is_letter(c)) model_step();
            chk("rnd_dout", {24'd0, rd}, {24'd0, is_letter(c) ? c + 8'd9 : c});
            chk("rnd_err", {31'd0, re}, 32'd0);
            chk("rnd_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});
            chk("rnd_latency", lat, is_letter(c) ? 2 + 9 * (2 + stub_lat) : 1);
        end
        stub_lat = 0;

        // Stage 4 never answers -> timeout
        hang_sel = 4'd4;
        send("K", 1'b0, '0, '0, rd, re, lat);
        model_step();
        chk("tmo_err", {31'd0, re}, 32'd1);
        chk("tmo_dout", {24'd0, rd}, 32'd0);
        chk("tmo_latency", lat, 19);
        chk("tmo_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});
        hang_sel = 4'hF;

        // valid and set mid-character are dropped
        req_q.delete();
        valid = 1'b1; din = "C";
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        valid = 1'b1; din = "Z"; set = 1'b1; cfg_pos = {5'd7, 5'd7, 5'd7}; cfg_notch = '0;
        @(posedge clk); #1;
        valid = 1'b0; set = 1'b0;
        wait_done(lat);
        model_step();
        chk("ign_dout", {24'd0, dout}, {24'd0, 8'h43 + 8'd9});
        chk("ign_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});
        @(posedge clk); #1;
        chk("ign_idle", {31'd0, ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_no_second", {31'd0, done}, 32'd0);

        // Reset during WAIT
        valid = 1'b1; din = "B";
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", {30'd0, ready, stg_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("rst2_ready", {31'd0, ready}, 32'd1);
        chk("rst2_done", {31'd0, done}, 32'd0);
        chk("rst2_pos", {17'd0, pos_l, pos_m, pos_r}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst2_no_done", {31'd0, done}, 32'd0);

        // Default notches: right rotor reaches notch 'V' and carries into middle
        for (int i = 0; i < 23; i++) begin
            send("E", 1'b0, '0, '0, rd, re, lat);
            model_step();
        end
        chk("dflt_notch_pos", {17'd0, pos_l, pos_m, pos_r}, {17'd0, model_pos()});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
